// File: rtl/cla_pipe_pkg.sv
// cla_pipe_pkg: shared sizing helpers, parameter legality check and skid occupancy states
// for the pipelined carry-lookahead adder (cla_pipe) and its chunk adder (cla_chunk).
package cla_pipe_pkg;

    localparam int unsigned GROUP = 4;

    function automatic int unsigned chunk_width(input int unsigned width, input int unsigned stages);
        return (stages == 0) ? 0 : width / stages;
    endfunction

    function automatic bit params_legal(input int unsigned width, input int unsigned stages);
        if (stages == 0 || width == 0) return 1'b0;
        if ((width % stages) != 0) return 1'b0;
        return ((width / stages) % GROUP) == 0;
    endfunction

    // Result bundle is {ovf, cout, sum}.
    function automatic int unsigned result_width(input int unsigned width);
        return width + 2;
    endfunction

    typedef enum logic [1:0] {
        SK_EMPTY,
        SK_ONE,
        SK_TWO
    } skid_state_e;

endpackage

// File: rtl/cla_pipe_chunk.sv
// cla_chunk: combinational WIDTH-bit carry-lookahead adder built from 4-bit lookahead
// groups joined by a group-level lookahead carry network.
module cla_chunk
    import cla_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NG = WIDTH / GROUP;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic [NG:0]      gc;
    logic             gc_term;
    logic             gc_acc;
    logic             bc_term;
    logic             bc_acc;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        gg = '0;
        gp = '1;
        for (int unsigned j = 0; j < NG; j++) begin
            for (int unsigned t = 0; t < GROUP; t++) begin
                gg[j] = g[j*GROUP+t] | (p[j*GROUP+t] & gg[j]);
                gp[j] = gp[j] & p[j*GROUP+t];
            end
        end
    end

    // Each group carry is a flat sum of products over group generate/propagate terms.
    always_comb begin
        gc      = '0;
        gc_term = 1'b0;
        gc_acc  = 1'b0;
        for (int unsigned j = 0; j <= NG; j++) begin
            gc_term = cin;
            for (int unsigned m = 0; m < j; m++) gc_term = gc_term & gp[m];
            gc_acc = gc_term;
            for (int unsigned i = 1; i <= j; i++) begin
                gc_term = gg[i-1];
                for (int unsigned m = i; m < j; m++) gc_term = gc_term & gp[m];
                gc_acc = gc_acc | gc_term;
            end
            gc[j] = gc_acc;
        end
    end

    always_comb begin
        c       = '0;
        bc_term = 1'b0;
        bc_acc  = 1'b0;
        for (int unsigned j = 0; j < NG; j++) begin
            for (int unsigned t = 0; t < GROUP; t++) begin
                bc_term = gc[j];
                for (int unsigned m = 0; m < t; m++) bc_term = bc_term & p[j*GROUP+m];
                bc_acc = bc_term;
                for (int unsigned i = 1; i <= t; i++) begin
                    bc_term = g[j*GROUP+i-1];
                    for (int unsigned m = i; m < t; m++) bc_term = bc_term & p[j*GROUP+m];
                    bc_acc = bc_acc | bc_term;
                end
                c[j*GROUP+t] = bc_acc;
            end
        end
    end

    assign sum  = p ^ c;
    assign cout = gc[NG];

endmodule

// File: rtl/cla_pipe.sv
// cla_pipe: pipelined add/subtract, one CHUNK-bit lookahead add per stage, valid/ready both sides.
// Define CLA_PIPE_SKID_EN for a 2-entry output skid that removes the out_ready -> in_ready path.
module cla_pipe
    import cla_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);
    localparam int unsigned RW    = result_width(WIDTH);

    if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
        $error("cla_pipe: WIDTH must divide into STAGES chunks that are multiples of 4 bits");
    end

    // Operands stay whole in every stage; only the chunks above k are still consumed downstream.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             sub;
    } stage_t;

    stage_t            st_q   [STAGES];
    stage_t            st_in  [STAGES];
    stage_t            st_d   [STAGES];
    logic [CHUNK-1:0]  ck_sum [STAGES];
    logic              ck_cout[STAGES];
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic              last_room;
    logic              room;
    logic              ovf_last;
    logic [RW-1:0]     res_last;

    always_comb begin
        st_in[0].a   = a;
        st_in[0].b   = sub ? ~b : b;
        st_in[0].s   = '0;
        st_in[0].c   = sub ? 1'b1 : cin;
        st_in[0].sub = sub;
        for (int unsigned k = 1; k < STAGES; k++) st_in[k] = st_q[k-1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_chunk #(
            .WIDTH(CHUNK)
        ) u_chunk (
            .a   (st_in[k].a[k*CHUNK +: CHUNK]),
            .b   (st_in[k].b[k*CHUNK +: CHUNK]),
            .cin (st_in[k].c),
            .sum (ck_sum[k]),
            .cout(ck_cout[k])
        );
    end

    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            st_d[k]                     = st_in[k];
            st_d[k].s[k*CHUNK +: CHUNK] = ck_sum[k];
            st_d[k].c                   = ck_cout[k];
        end
    end

    // Walk from the output back: a stage moves if it is full and the one ahead is free or moving.
    always_comb begin
        adv  = '0;
        load = '0;
        room = last_room;
        for (int unsigned i = 0; i < STAGES; i++) begin
            adv[STAGES-1-i] = v_q[STAGES-1-i] && room;
            room            = !v_q[STAGES-1-i] || adv[STAGES-1-i];
        end
        load[0] = in_valid && room;
        for (int unsigned k = 1; k < STAGES; k++) load[k] = adv[k-1];
    end

    assign in_ready = room;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) st_q[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (load[k]) st_q[k] <= st_d[k];
            end
            v_q <= load | (v_q & ~adv);
        end
    end

    assign ovf_last = (st_q[STAGES-1].a[WIDTH-1] == st_q[STAGES-1].b[WIDTH-1])
                   && (st_q[STAGES-1].s[WIDTH-1] != st_q[STAGES-1].a[WIDTH-1]);
    assign res_last = {ovf_last, st_q[STAGES-1].c, st_q[STAGES-1].s};

`ifdef CLA_PIPE_SKID_EN
    skid_state_e   sk_state_q;
    skid_state_e   sk_state_d;
    logic [RW-1:0] sk0_q;
    logic [RW-1:0] sk0_d;
    logic [RW-1:0] sk1_q;
    logic [RW-1:0] sk1_d;
    logic          sk_pop;
    logic          sk_push;

    assign last_room = (sk_state_q != SK_TWO);

    // With an empty skid the last stage is presented directly; it only enters the skid if not taken.
    always_comb begin
        sk_state_d = sk_state_q;
        sk0_d      = sk0_q;
        sk1_d      = sk1_q;
        sk_pop     = (sk_state_q != SK_EMPTY) && out_ready;
        sk_push    = adv[STAGES-1] && !((sk_state_q == SK_EMPTY) && out_ready);
        case (sk_state_q)
            SK_EMPTY: begin
                if (sk_push) begin
                    sk0_d      = res_last;
                    sk_state_d = SK_ONE;
                end
            end
            SK_ONE: begin
                if (sk_pop && sk_push) begin
                    sk0_d = res_last;
                end else if (sk_pop) begin
                    sk_state_d = SK_EMPTY;
                end else if (sk_push) begin
                    sk1_d      = res_last;
                    sk_state_d = SK_TWO;
                end
            end
            SK_TWO: begin
                if (sk_pop) begin
                    sk0_d      = sk1_q;
                    sk_state_d = SK_ONE;
                end
            end
            default: sk_state_d = SK_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sk_state_q <= SK_EMPTY;
            sk0_q      <= '0;
            sk1_q      <= '0;
        end else begin
            sk_state_q <= sk_state_d;
            sk0_q      <= sk0_d;
            sk1_q      <= sk1_d;
        end
    end

    assign out_valid          = (sk_state_q != SK_EMPTY) || v_q[STAGES-1];
    assign {ovf, cout, sum}   = (sk_state_q != SK_EMPTY) ? sk0_q : res_last;
`else
    assign last_room          = out_ready;
    assign out_valid          = v_q[STAGES-1];
    assign {ovf, cout, sum}   = res_last;
`endif

endmodule
